bcp_clause_scanner: RTL and testbench

Sequential clause evaluator for the BCP unit. On `start`, it walks the literals of one clause (up to 8), one per cycle, by driving the 3-bit select of the two 8:1 literal multiplexers (assigned-bit mux and value-bit mux). It consumes their combinational outputs and classifies the clause as satisfied, unit, conflicting or unresolved. The result is returned over a valid/ready handshake to the BCP control logic, together with the index of the first unassigned literal.

---
 rtl/bcp_pkg.sv | 35 +++
 rtl/bcp_lit_tracker.sv | 79 +++++++
 rtl/bcp_clause_scanner.sv | 160 ++++++++++++++++
 tb/tb_bcp_clause_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bcp_pkg.sv
// Shared types and constants for the BCP clause scanner and its literal tracker.
package bcp_pkg;

  localparam int MAX_LITS = 8;
  localparam int SEL_W    = $clog2(MAX_LITS);

  typedef enum logic [1:0] {
    RES_SAT      = 2'b00,
    RES_UNIT     = 2'b01,
    RES_CONFLICT = 2'b10,
    RES_UNRES    = 2'b11
  } bcp_res_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } scan_state_e;

  // A true literal dominates; otherwise the unassigned count decides.
  function automatic bcp_res_e classify(input logic any_true, input logic [1:0] unassigned_cnt);
    bcp_res_e res;
    if (any_true) begin
      res = RES_SAT;
    end else if (unassigned_cnt == 2'd0) begin
      res = RES_CONFLICT;
    end else if (unassigned_cnt == 2'd1) begin
      res = RES_UNIT;
    end else begin
      res = RES_UNRES;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcp_lit_tracker.sv
// Accumulates per-clause literal statistics; outputs already fold in the literal
// presented this cycle so the scanner can classify on the final literal's cycle.
module bcp_lit_tracker
  import bcp_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [SEL_W-1:0] i_idx,
  input  logic             i_lit_assigned,
  input  logic             i_lit_value,
  output logic             o_any_true,
  output logic [1:0]       o_unassigned_cnt,
  output logic [SEL_W-1:0] o_first_idx
);

  logic             r_any_true;
  logic [1:0]       r_cnt;
  logic [SEL_W-1:0] r_first_idx;

  logic             w_any_true;
  logic [1:0]       w_cnt;
  logic [SEL_W-1:0] w_first_idx;

  always_comb begin
    w_any_true  = r_any_true;
    w_cnt       = r_cnt;
    w_first_idx = r_first_idx;
    if (i_en) begin
      if (i_lit_assigned) begin
        if (i_lit_value) begin
          w_any_true = 1'b1;
        end else begin
          w_any_true = r_any_true;
        end
      end else begin
        if (r_cnt == 2'd0) begin
          w_first_idx = i_idx;
        end else begin
          w_first_idx = r_first_idx;
        end
        // Saturate at 2: the classification only needs zero / one / many.
        if (r_cnt != 2'd2) begin
          w_cnt = r_cnt + 2'd1;
        end else begin
          w_cnt = r_cnt;
        end
      end
    end else begin
      w_any_true  = r_any_true;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_any_true  <= 1'b0;
      r_cnt       <= 2'd0;
      r_first_idx <= '0;
    end else if (i_clear) begin
      r_any_true  <= 1'b0;
      r_cnt       <= 2'd0;
      r_first_idx <= '0;
    end else if (i_en) begin
      r_any_true  <= w_any_true;
      r_cnt       <= w_cnt;
      r_first_idx <= w_first_idx;
    end else begin
      r_any_true  <= r_any_true;
      r_cnt       <= r_cnt;
      r_first_idx <= r_first_idx;
    end
  end

  assign o_any_true       = w_any_true;
  assign o_unassigned_cnt = w_cnt;
  assign o_first_idx      = w_first_idx;

endmodule

// File: rtl/bcp_clause_scanner.sv
// Walks up to MAX_LITS literals of one clause through the external literal muxes
// and returns SAT / UNIT / CONFLICT / UNRES over a valid/ready handshake.
module bcp_clause_scanner
  import bcp_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_clause_len,
  input  logic             i_abort,
  output logic [SEL_W-1:0] o_sel,
  input  logic             i_lit_assigned,
  input  logic             i_lit_value,
  output logic             o_busy,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [1:0]       o_res_code,
  output logic [SEL_W-1:0] o_unit_idx
);

  localparam logic [LEN_W-1:0] LP_MAX_LEN = LEN_W'(MAX_LITS);

  scan_state_e      r_state;
  logic [SEL_W-1:0] r_idx;
  logic [SEL_W-1:0] r_last;
  logic             r_busy;
  logic             r_res_valid;
  bcp_res_e         r_res_code;
  logic [SEL_W-1:0] r_unit_idx;

  logic [LEN_W-1:0] w_len_clamped;
  logic [SEL_W-1:0] w_last;
  logic             w_en;
  logic             w_clear;
  logic             w_scan_end;
  logic             w_any_true;
  logic [1:0]       w_cnt;
  logic [SEL_W-1:0] w_first_idx;
  bcp_res_e         w_res_code;
  logic [SEL_W-1:0] w_unit_idx;

  always_comb begin
    if (i_clause_len > LP_MAX_LEN) begin
      w_len_clamped = LP_MAX_LEN;
    end else begin
      w_len_clamped = i_clause_len;
    end
    w_last = SEL_W'(w_len_clamped - LEN_W'(1));
  end

  // Tracker update/clear strobes; abort and a completed handshake both wipe it.
  always_comb begin
    w_en    = (r_state == SCAN) && !i_abort;
    w_clear = 1'b0;
    if (r_state != IDLE && i_abort) begin
      w_clear = 1'b1;
    end else if (r_state == DONE && r_res_valid && i_res_ready) begin
      w_clear = 1'b1;
    end else begin
      w_clear = 1'b0;
    end
  end

  bcp_lit_tracker u_tracker (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_clear          (w_clear),
    .i_en             (w_en),
    .i_idx            (r_idx),
    .i_lit_assigned   (i_lit_assigned),
    .i_lit_value      (i_lit_value),
    .o_any_true       (w_any_true),
    .o_unassigned_cnt (w_cnt),
    .o_first_idx      (w_first_idx)
  );

  always_comb begin
    w_scan_end = w_any_true || (r_idx == r_last);
    w_res_code = classify(w_any_true, w_cnt);
    if (w_res_code == RES_UNIT || w_res_code == RES_UNRES) begin
      w_unit_idx = w_first_idx;
    end else begin
      w_unit_idx = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_last      <= '0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_code  <= RES_SAT;
      r_unit_idx  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start && i_clause_len == '0) begin
            r_state     <= DONE;
            r_busy      <= 1'b1;
            r_res_valid <= 1'b1;
            r_res_code  <= RES_CONFLICT;
            r_unit_idx  <= '0;
          end else if (i_start) begin
            r_state <= SCAN;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_last  <= w_last;
          end else begin
            r_state <= IDLE;
          end
        end
        SCAN: begin
          if (i_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_idx   <= '0;
          end else if (w_scan_end) begin
            r_state     <= DONE;
            r_idx       <= '0;
            r_res_valid <= 1'b1;
            r_res_code  <= w_res_code;
            r_unit_idx  <= w_unit_idx;
          end else begin
            r_idx <= r_idx + SEL_W'(1);
          end
        end
        DONE: begin
          if (i_abort || (r_res_valid && i_res_ready)) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_code  <= RES_SAT;
            r_unit_idx  <= '0;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_idx       <= '0;
          r_busy      <= 1'b0;
          r_res_valid <= 1'b0;
          r_res_code  <= RES_SAT;
          r_unit_idx  <= '0;
        end
      endcase
    end
  end

  assign o_sel       = r_idx;
  assign o_busy      = r_busy;
  assign o_res_valid = r_res_valid;
  assign o_res_code  = r_res_code;
  assign o_unit_idx  = r_unit_idx;

endmodule

// File: tb/tb_bcp_clause_scanner.sv
// Directed bench for bcp_clause_scanner; the literal muxes are modelled from two
// bench-driven 8-bit vectors indexed by the scanner's select.
module tb_bcp_clause_scanner;
  import bcp_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] clause_len;
  logic       abort;
  logic [2:0] sel;
  logic       lit_assigned;
  logic       lit_value;
  logic       busy;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] res_code;
  logic [2:0] unit_idx;

  logic [7:0] lits_a;
  logic [7:0] lits_v;

  int n_checks;
  int n_fail;

  assign lit_assigned = lits_a[sel];
  assign lit_value    = lits_v[sel];

  bcp_clause_scanner #(.LEN_W(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_clause_len   (clause_len),
    .i_abort        (abort),
    .o_sel          (sel),
    .i_lit_assigned (lit_assigned),
    .i_lit_value    (lit_value),
    .o_busy         (busy),
    .o_res_valid    (res_valid),
    .i_res_ready    (res_ready),
    .o_res_code     (res_code),
    .o_unit_idx     (unit_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a scan from IDLE, walks it to the result and completes the handshake.
  task automatic run_scan(input string tag, input logic [3:0] len, input int exp_cyc,
                          input logic [1:0] exp_code, input logic [2:0] exp_idx,
                          input int exp_max_sel);
    int   cyc;
    int   max_sel;
    logic seq_ok;
    clause_len = len;
    start      = 1'b1;
    res_ready  = 1'b0;
    tick();
    start   = 1'b0;
    cyc     = 1;
    max_sel = 0;
    seq_ok  = 1'b1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!res_valid && cyc < 30) begin
      if (int'(sel) != cyc - 1) seq_ok = 1'b0;
      if (int'(sel) > max_sel) max_sel = int'(sel);
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_code"}, 32'(res_code), 32'(exp_code));
    check({tag, "_unit_idx"}, 32'(unit_idx), 32'(exp_idx));
    check({tag, "_max_sel"}, 32'(max_sel), 32'(exp_max_sel));
    check({tag, "_sel_seq"}, 32'(seq_ok), 32'd1);
    check({tag, "_sel_done"}, 32'(sel), 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_valid_after"}, 32'(res_valid), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    clause_len = 4'd0;
    abort      = 1'b0;
    res_ready  = 1'b0;
    lits_a     = 8'hFF;
    lits_v     = 8'h00;

    #12;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_code", 32'(res_code), 32'd0);
    check("rst_unit_idx", 32'(unit_idx), 32'd0);
    rst = 1'b0;
    tick();

    lits_a = 8'b1111_1101; lits_v = 8'h00;
    run_scan("unit3", 4'd3, 4, RES_UNIT, 3'd1, 2);

    lits_a = 8'hFF; lits_v = 8'h00;
    run_scan("conf8", 4'd8, 9, RES_CONFLICT, 3'd0, 7);

    lits_a = 8'hFF; lits_v = 8'b0000_0100;
    run_scan("sat8", 4'd8, 4, RES_SAT, 3'd0, 2);

    lits_a = 8'b1111_0101; lits_v = 8'h00;
    run_scan("unres5", 4'd5, 6, RES_UNRES, 3'd1, 4);

    lits_a = 8'b0111_1111; lits_v = 8'h00;
    run_scan("clamp12", 4'd12, 9, RES_UNIT, 3'd7, 7);

    // Empty clause with back-pressure and a stray start during DONE.
    clause_len = 4'd0;
    start      = 1'b1;
    res_ready  = 1'b0;
    tick();
    check("len0_valid_c1", 32'(res_valid), 32'd1);
    check("len0_code_c1", 32'(res_code), 32'(RES_CONFLICT));
    check("len0_busy_c1", 32'(busy), 32'd1);
    clause_len = 4'd3;
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      tick();
      check("len0_hold_valid", 32'(res_valid), 32'd1);
      check("len0_hold_code", 32'(res_code), 32'(RES_CONFLICT));
      check("len0_hold_idx", 32'(unit_idx), 32'd0);
      check("len0_hold_sel", 32'(sel), 32'd0);
    end
    start     = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("len0_idle_valid", 32'(res_valid), 32'd0);
    check("len0_idle_busy", 32'(busy), 32'd0);
    tick();
    check("len0_no_queue", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a scan.
    lits_a     = 8'hFF; lits_v = 8'h00;
    clause_len = 4'd8;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("arst_pre_sel", 32'(sel), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(res_valid), 32'd0);
    check("arst_code", 32'(res_code), 32'd0);
    rst = 1'b0;
    tick();
    check("arst_idle_busy", 32'(busy), 32'd0);

    // Abort in cycle 3 after two unassigned literals; a later scan must not see them.
    lits_a     = 8'b1111_1100; lits_v = 8'h00;
    clause_len = 4'd8;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort_sel_c3", 32'(sel), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sel", 32'(sel), 32'd0);
    check("abort_valid", 32'(res_valid), 32'd0);
    tick();
    check("abort_no_result", 32'(res_valid), 32'd0);
    lits_a = 8'hFF; lits_v = 8'h00;
    run_scan("post_abort", 4'd3, 4, RES_CONFLICT, 3'd0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
